// File: rtl/logic_op_arbiter.sv
// Two-requester front end for one shared bitwise logic unit.
// Each operation goes IDLE (grant) -> EXEC (compute) -> RESP (hold until consumed).
module logic_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_src,
  output logic             resp_err,
  output logic [15:0]      ops_done,
  output logic [1:0]       fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends on anything but state, valids and last_grant.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             grant0;
  logic             grant1;
  logic [2:0]       cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic             cap_src;
  logic [WIDTH-1:0] alu_data;
  logic             alu_err;

  assign fsm_state = state;

  // Round-robin: on a tie the requester that did not win last time goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last_grant) grant0 = 1'b1;
      else            grant1 = 1'b1;
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  always_comb begin
    alu_err  = 1'b0;
    alu_data = '0;
    case (cap_op)
      3'd0: alu_data = cap_a & cap_b;
      3'd1: alu_data = cap_a | cap_b;
      3'd2: alu_data = ~cap_a;
      3'd3: alu_data = ~(cap_a & cap_b);
      3'd4: alu_data = ~(cap_a | cap_b);
      3'd5: alu_data = cap_a ^ cap_b;
      3'd6: alu_data = ~(cap_a ^ cap_b);
      default: alu_err = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req0_ready || req1_ready) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; rst_n gating keeps readys low while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0 && rst_n;
        req1_ready = grant1 && rst_n;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands are captured at accept so later requester changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cap_op     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_src    <= 1'b0;
      resp_data  <= '0;
      resp_src   <= 1'b0;
      resp_err   <= 1'b0;
      ops_done   <= '0;
    end else begin
      if (req0_ready) begin
        cap_op     <= req0_op;
        cap_a      <= req0_a;
        cap_b      <= req0_b;
        cap_src    <= 1'b0;
        last_grant <= 1'b0;
      end else if (req1_ready) begin
        cap_op     <= req1_op;
        cap_a      <= req1_a;
        cap_b      <= req1_b;
        cap_src    <= 1'b1;
        last_grant <= 1'b1;
      end
      if (state == EXEC) begin
        resp_data <= alu_data;
        resp_src  <= cap_src;
        resp_err  <= alu_err;
      end
      if (resp_valid && resp_ready) ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: vector table plus hand-written
// arbitration, backpressure, reset-mid-op and counter-wrap sequences.
module tb_logic_op_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [2:0]       req0_op, req1_op;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             resp_valid, resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_src, resp_err;
  logic [15:0]      ops_done;
  logic [1:0]       fsm_state;

  int tests;
  int failed;
  logic [15:0] exp_ops;
  logic [WIDTH+1:0] exp_q[$];  // {err, src, data}

  typedef struct {
    logic             src;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err;
  } vec_t;

  vec_t vecs[12];

  logic_op_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_src(resp_src), .resp_err(resp_err),
    .ops_done(ops_done), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    rst_n   = 1'b1;
    exp_ops = 16'd0;
  endtask

  task automatic drive(input logic src, input logic v, input logic [2:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (src) begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; end
    else     begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  // Driver + scoreboard for one operation; stall = cycles of resp_ready low in RESP.
  task automatic run_op(input logic src, input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_data,
                        input logic exp_err, input int stall);
    logic got;
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] held;
    got = 1'b0;
    @(negedge clk);
    resp_ready = (stall == 0);
    drive(src, 1'b1, op, a, b);
    exp_q.push_back({exp_err, src, exp_data});
    for (int i = 0; i < 10; i++) begin
      #1;
      if ((src ? req1_ready : req0_ready) === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("accept_ready", {31'd0, got}, 32'd1);
    if (!got) begin
      drive(src, 1'b0, 3'd0, '0, '0);
      void'(exp_q.pop_front());
      return;
    end
    @(negedge clk);
    // Scramble inputs after accept; result must not change.
    drive(src, 1'b0, 3'($urandom_range(0, 7)), WIDTH'($urandom_range(0, 255)),
          WIDTH'($urandom_range(0, 255)));
    check("exec_no_resp", {31'd0, resp_valid}, 32'd0);
    check("exec_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    @(negedge clk);
    exp = exp_q.pop_front();
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_data", {24'd0, resp_data}, {24'd0, exp[WIDTH-1:0]});
    check("resp_src", {31'd0, resp_src}, {31'd0, exp[WIDTH]});
    check("resp_err", {31'd0, resp_err}, {31'd0, exp[WIDTH+1]});
    held = resp_data;
    if (stall > 0) begin
      drive(!src, 1'b1, 3'd0, 8'hFF, 8'hFF);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("stall_valid", {31'd0, resp_valid}, 32'd1);
        check("stall_data", {24'd0, resp_data}, {24'd0, held});
        check("stall_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        check("stall_ops", {16'd0, ops_done}, {16'd0, exp_ops});
      end
      drive(!src, 1'b0, 3'd0, '0, '0);
      resp_ready = 1'b1;
    end
    @(negedge clk);
    exp_ops = exp_ops + 16'd1;
    check("done_valid_low", {31'd0, resp_valid}, 32'd0);
    check("ops_done", {16'd0, ops_done}, {16'd0, exp_ops});
  endtask

  initial begin
    logic [1:0] grants[4];
    int ng;
    tests = 0; failed = 0; exp_ops = 16'd0;
    rst_n = 1'b0; resp_ready = 1'b1;
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    drive(1'b1, 1'b0, 3'd0, '0, '0);

    vecs[0]  = '{1'b0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 8'hA5, 8'h0F, 8'h05, 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0};
    vecs[3]  = '{1'b1, 3'd2, 8'hA5, 8'h0F, 8'h5A, 1'b0};
    vecs[4]  = '{1'b1, 3'd3, 8'hA5, 8'h0F, 8'hFA, 1'b0};
    vecs[5]  = '{1'b1, 3'd4, 8'hA5, 8'h0F, 8'h50, 1'b0};
    vecs[6]  = '{1'b1, 3'd5, 8'hA5, 8'h0F, 8'hAA, 1'b0};
    vecs[7]  = '{1'b1, 3'd6, 8'hA5, 8'h0F, 8'h55, 1'b0};
    vecs[8]  = '{1'b1, 3'd7, 8'hA5, 8'h0F, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 3'd2, 8'h00, 8'hFF, 8'hFF, 1'b0};
    vecs[10] = '{1'b0, 3'd6, 8'h3C, 8'hC3, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 3'd5, 8'hFF, 8'hFF, 8'h00, 1'b0};

    // Reset values, with both requesters already pending.
    drive(1'b0, 1'b1, 3'd1, 8'h01, 8'h02);
    drive(1'b1, 1'b1, 3'd1, 8'h04, 8'h08);
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", {24'd0, resp_data}, 32'd0);
    check("rst_src_err", {30'd0, resp_src, resp_err}, 32'd0);
    check("rst_ops", {16'd0, ops_done}, 32'd0);

    // Arbitration from reset: grants must alternate 0,1,0,1.
    release_reset();
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      check("one_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
      if (fsm_state != 2'd0)
        check("ready_outside_idle", {30'd0, req0_ready, req1_ready}, 32'd0);
      if (req0_ready)      begin grants[ng] = 2'd0; ng++; end
      else if (req1_ready) begin grants[ng] = 2'd1; ng++; end
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    drive(1'b1, 1'b0, 3'd0, '0, '0);
    check("grant_count", ng, 4);
    for (int k = 0; k < ng; k++) check("grant_order", {30'd0, grants[k]}, k % 2);
    repeat (4) @(negedge clk);
    exp_ops = 16'd4;
    check("arb_ops", {16'd0, ops_done}, {16'd0, exp_ops});

    // Vector table from a fresh reset.
    do_reset();
    release_reset();
    for (int i = 0; i < 12; i++)
      run_op(vecs[i].src, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_data, vecs[i].exp_err, 0);

    // Backpressure: resp_ready low for 5 cycles in RESP.
    run_op(1'b0, 3'd1, 8'h12, 8'h81, 8'h93, 1'b0, 5);

    // Reset during EXEC discards the op.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd4, 8'h00, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, '0, '0);
    check("pre_rst_exec", {30'd0, fsm_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", {30'd0, fsm_state}, 32'd0);
    check("mid_rst_data", {24'd0, resp_data}, 32'd0);
    check("mid_rst_ops", {16'd0, ops_done}, 32'd0);
    @(negedge clk);
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    release_reset();
    run_op(1'b0, 3'd5, 8'hFF, 8'h0F, 8'hF0, 1'b0, 0);

    // Counter wrap: preload near the top, then two completions.
    @(negedge clk);
    force dut.ops_done = 16'hFFFE;
    #1;
    release dut.ops_done;
    exp_ops = 16'hFFFE;
    run_op(1'b1, 3'd0, 8'hFF, 8'h0F, 8'h0F, 1'b0, 0);
    run_op(1'b0, 3'd1, 8'h00, 8'h00, 8'h00, 1'b0, 0);
    check("wrap_zero", {16'd0, ops_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
